// File: rtl/slave_xspi_ctrl_if.sv
// PHY-side and word-memory signals of the xSPI slave controller.
// The slave modport is the controller; the master modport is the PHY/memory side.
interface slave_xspi_ctrl_if;
    logic        cs_in;
    logic [1:0]  mode_sel;
    logic [15:0] phy_out;
    logic        rd_en;
    logic        sdr_en;
    logic        ddr_1_en;
    logic        ddr_2_en;
    logic [15:0] io_in;
    logic        ds_in;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        cmd_err;

    modport slave (
        input  cs_in, mode_sel, phy_out, mem_rdata,
        output rd_en, sdr_en, ddr_1_en, ddr_2_en, io_in, ds_in,
        output mem_addr, mem_wdata, mem_we, mem_re, busy, cmd_err
    );

    modport master (
        output cs_in, mode_sel, phy_out, mem_rdata,
        input  rd_en, sdr_en, ddr_1_en, ddr_2_en, io_in, ds_in,
        input  mem_addr, mem_wdata, mem_we, mem_re, busy, cmd_err
    );
endinterface

// File: rtl/slave_xspi_ctrl.sv
// xSPI slave command/address/data sequencer bridging an SDR/DDR PHY to a word memory.
// Reads prefetch two clocks ahead of the PHY so memory latency is hidden.
module slave_xspi_ctrl #(
    parameter logic [7:0]  RD_OP     = 8'h0B,
    parameter logic [7:0]  WR_OP     = 8'h12,
    parameter int unsigned DUMMY_CYC = 8
) (
    input logic              clk,
    input logic              reset,
    slave_xspi_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        StIdle, StCmd, StAddr, StDummy, StWdata, StRdata, StIgnore
    } state_t;

    localparam logic [4:0] RE0_CNT  = 5'(DUMMY_CYC - 3);
    localparam logic [4:0] RE1_CNT  = 5'(DUMMY_CYC - 2);
    localparam logic [4:0] LAST_CNT = 5'(DUMMY_CYC - 1);

    state_t      r_state;
    logic [1:0]  r_mode;
    logic [4:0]  r_cnt;
    logic [30:0] r_sh;
    logic [31:0] r_addr;
    logic [15:0] r_buf;
    logic [15:0] r_wdata;
    logic        r_is_rd;
    logic        r_cs_q;
    logic        r_mem_re;
    logic        r_mem_we;
    logic        r_rd_pend;
    logic        r_last;
    logic        r_cmd_err;

    logic        w_ddr;
    logic        w_bit;
    logic [7:0]  w_op;
    logic        w_cmd_ok;
    logic        w_active;
    logic        w_rdata;
    logic        w_sdr_bit;

    assign w_ddr    = (r_mode != 2'b00);
    assign w_bit    = bus.phy_out[0];
    assign w_op     = w_ddr ? bus.phy_out[15:8] : {r_sh[6:0], w_bit};
    assign w_cmd_ok = ((w_op == RD_OP) || (w_op == WR_OP)) &&
                      (!w_ddr || (bus.phy_out[7:0] == ~bus.phy_out[15:8]));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= StIdle;
            r_mode    <= 2'b00;
            r_cnt     <= '0;
            r_sh      <= '0;
            r_addr    <= '0;
            r_buf     <= '0;
            r_wdata   <= '0;
            r_is_rd   <= 1'b0;
            r_cs_q    <= 1'b0;
            r_mem_re  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_rd_pend <= 1'b0;
            r_last    <= 1'b0;
            r_cmd_err <= 1'b0;
        end else begin
            r_cs_q    <= bus.cs_in;
            r_cmd_err <= 1'b0;
            r_mem_re  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_rd_pend <= r_mem_re;
            // Keeps the final SDR bit of a word alive while the next word loads.
            r_last    <= r_buf[0];
            if (r_rd_pend) r_buf <= bus.mem_rdata;
            if (r_mem_re || r_mem_we) r_addr <= r_addr + 32'd1;

            if (bus.cs_in) begin
                r_state <= StIdle;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        // Only a fresh falling edge of cs_in starts a transaction.
                        if (r_cs_q) begin
                            r_mode  <= (bus.mode_sel == 2'b11) ? 2'b00 : bus.mode_sel;
                            r_cnt   <= '0;
                            r_state <= StCmd;
                        end
                    end
                    StCmd: begin
                        r_sh <= {r_sh[29:0], w_bit};
                        if (w_ddr || (r_cnt == 5'd7)) begin
                            r_cnt <= '0;
                            if (w_cmd_ok) begin
                                r_is_rd <= (w_op == RD_OP);
                                r_state <= StAddr;
                            end else begin
                                r_cmd_err <= 1'b1;
                                r_state   <= StIgnore;
                            end
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                    StAddr: begin
                        if (w_ddr) begin
                            r_sh[15:0] <= bus.phy_out;
                            if (r_cnt != 5'd0) r_addr <= {r_sh[15:0], bus.phy_out};
                        end else begin
                            r_sh <= {r_sh[29:0], w_bit};
                            if (r_cnt == 5'd31) r_addr <= {r_sh, w_bit};
                        end
                        if ((w_ddr && r_cnt != 5'd0) || r_cnt == 5'd31) begin
                            r_cnt   <= '0;
                            r_state <= r_is_rd ? StDummy : StWdata;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                    StDummy: begin
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == RE0_CNT) r_mem_re <= 1'b1;
                        if (r_cnt == RE1_CNT && w_ddr) r_mem_re <= 1'b1;
                        if (r_cnt == LAST_CNT) begin
                            r_cnt    <= '0;
                            r_mem_re <= w_ddr;
                            r_state  <= StRdata;
                        end
                    end
                    StRdata: begin
                        if (w_ddr) begin
                            r_mem_re <= 1'b1;
                        end else begin
                            r_cnt    <= (r_cnt[3:0] == 4'd15) ? 5'd0 : r_cnt + 5'd1;
                            r_mem_re <= (r_cnt == 5'd12);
                        end
                    end
                    StWdata: begin
                        if (w_ddr) begin
                            r_wdata  <= bus.phy_out;
                            r_mem_we <= 1'b1;
                        end else begin
                            r_sh <= {r_sh[29:0], w_bit};
                            if (r_cnt == 5'd15) begin
                                r_wdata  <= {r_sh[14:0], w_bit};
                                r_mem_we <= 1'b1;
                                r_cnt    <= '0;
                            end else begin
                                r_cnt <= r_cnt + 5'd1;
                            end
                        end
                    end
                    StIgnore: ;
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign w_active  = (r_state != StIdle) && (r_state != StIgnore);
    assign w_rdata   = (r_state == StRdata);
    assign w_sdr_bit = (r_cnt[3:0] == 4'd15) ? r_last : r_buf[~r_cnt[3:0]];

    assign bus.sdr_en    = w_active && (r_mode == 2'b00);
    assign bus.ddr_1_en  = w_active && (r_mode == 2'b01);
    assign bus.ddr_2_en  = w_active && (r_mode == 2'b10);
    assign bus.rd_en     = w_rdata;
    assign bus.ds_in     = w_rdata && w_ddr;
    assign bus.io_in     = !w_rdata ? 16'h0000 : (w_ddr ? r_buf : {14'b0, w_sdr_bit, 1'b0});
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_re    = r_mem_re;
    assign bus.busy      = (r_state != StIdle);
    assign bus.cmd_err   = r_cmd_err;
endmodule

// File: tb/tb_slave_xspi_ctrl.sv
// Directed bench for slave_xspi_ctrl: DDR/SDR reads and writes, bad command,
// address wrap, partial SDR word and reset during a read.
module tb_slave_xspi_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   re_cnt = 0;
    int   we_cnt = 0;
    int   clash_cnt = 0;
    logic [15:0] mem [0:255];
    logic [72:0] all_out;

    always #5 clk = ~clk;

    slave_xspi_ctrl_if bus ();

    slave_xspi_ctrl #(
        .RD_OP    (8'h0B),
        .WR_OP    (8'h12),
        .DUMMY_CYC(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    assign all_out = {bus.rd_en, bus.sdr_en, bus.ddr_1_en, bus.ddr_2_en, bus.io_in, bus.ds_in,
                      bus.mem_addr, bus.mem_wdata, bus.mem_we, bus.mem_re, bus.busy,
                      bus.cmd_err};

    // Word memory: read data valid the clock after mem_re.
    always @(posedge clk) begin
        if (bus.mem_re) begin
            bus.mem_rdata <= mem[bus.mem_addr[7:0]];
            re_cnt <= re_cnt + 1;
        end
        if (bus.mem_we) we_cnt <= we_cnt + 1;
        if (bus.mem_re && bus.mem_we) clash_cnt <= clash_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
        $fatal(1);
    end

    task automatic step(input logic cs, input logic [15:0] d);
        bus.cs_in   = cs;
        bus.phy_out = d;
        @(negedge clk);
    endtask

    task automatic send_sdr(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b0, {15'b0, v[i]});
    endtask

    task automatic begin_xfer(input logic [1:0] m);
        bus.mode_sel = m;
        step(1'b0, 16'h0000);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        bus.cs_in = 1'b0;
        bus.mode_sel = 2'b01;
        bus.phy_out = 16'hFFFF;
        repeat (2) @(negedge clk);
        checks++;
        if (all_out !== 73'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        reset = 1'b1;
        step(1'b1, 16'h0000);
        step(1'b1, 16'h0000);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b expected 0", bus.busy);
        end
    endtask

    task automatic test_ddr_read;
        logic [15:0] exp_w [3];
        exp_w = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
        mem[8'h10] = 16'hAAAA; mem[8'h11] = 16'hBBBB; mem[8'h12] = 16'hCCCC;
        mem[8'h13] = 16'hDDDD; mem[8'h14] = 16'hEEEE;
        begin_xfer(2'b01);
        bus.mode_sel = 2'b00;
        checks++;
        if ({bus.sdr_en, bus.ddr_1_en, bus.ddr_2_en, bus.busy} !== 4'b0101) begin
            failures++;
            $display("FAIL ddr_rd_enables: got %b expected 0101",
                     {bus.sdr_en, bus.ddr_1_en, bus.ddr_2_en, bus.busy});
        end
        step(1'b0, 16'h0BF4);
        step(1'b0, 16'h0000);
        step(1'b0, 16'h0010);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({bus.mem_re, bus.rd_en} !== {(i >= 6), 1'b0}) begin
                failures++;
                $display("FAIL ddr_dummy_%0d: re/rd_en=%b expected %b", i,
                         {bus.mem_re, bus.rd_en}, {(i >= 6), 1'b0});
            end
            if (i == 6) begin
                checks++;
                if (bus.mem_addr !== 32'h0000_0010) begin
                    failures++;
                    $display("FAIL ddr_first_addr: got %h expected 00000010", bus.mem_addr);
                end
            end
            step(1'b0, 16'h0000);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({bus.rd_en, bus.ds_in, bus.io_in} !== {2'b11, exp_w[k]}) begin
                failures++;
                $display("FAIL ddr_word_%0d: got %h expected %h", k,
                         {bus.rd_en, bus.ds_in, bus.io_in}, {2'b11, exp_w[k]});
            end
            step(1'b0, 16'h0000);
        end
        step(1'b1, 16'h0000);
        checks++;
        if ({bus.busy, bus.rd_en, bus.ds_in} !== 3'b000) begin
            failures++;
            $display("FAIL ddr_rd_end: got %b expected 000", {bus.busy, bus.rd_en, bus.ds_in});
        end
    endtask

    task automatic test_sdr_write;
        int we0;
        we0 = we_cnt;
        begin_xfer(2'b00);
        send_sdr(32'h12, 8);
        send_sdr(32'h0000_0004, 32);
        checks++;
        if ({bus.sdr_en, bus.ddr_1_en, bus.ddr_2_en, bus.rd_en} !== 4'b1000) begin
            failures++;
            $display("FAIL sdr_wr_enables: got %b expected 1000",
                     {bus.sdr_en, bus.ddr_1_en, bus.ddr_2_en, bus.rd_en});
        end
        send_sdr(32'h1234, 16);
        checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'h4, 16'h1234}) begin
            failures++;
            $display("FAIL sdr_wr_word0: got %h expected %h",
                     {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 32'h4, 16'h1234});
        end
        send_sdr(32'h5678, 16);
        checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'h5, 16'h5678}) begin
            failures++;
            $display("FAIL sdr_wr_word1: got %h expected %h",
                     {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 32'h5, 16'h5678});
        end
        step(1'b1, 16'h0000);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL sdr_wr_idle: busy=%b expected 0", bus.busy);
        end
        checks++;
        if (we_cnt - we0 !== 2) begin
            failures++;
            $display("FAIL sdr_wr_count: got %0d expected 2", we_cnt - we0);
        end
    endtask

    task automatic test_bad_cmd;
        int re0, we0;
        logic seen;
        re0 = re_cnt;
        we0 = we_cnt;
        seen = 1'b0;
        begin_xfer(2'b01);
        step(1'b0, 16'h0B0B);
        checks++;
        if ({bus.cmd_err, bus.busy, bus.rd_en} !== 3'b110) begin
            failures++;
            $display("FAIL bad_cmd_pulse: got %b expected 110",
                     {bus.cmd_err, bus.busy, bus.rd_en});
        end
        step(1'b0, 16'h0010);
        checks++;
        if ({bus.cmd_err, bus.busy} !== 2'b01) begin
            failures++;
            $display("FAIL bad_cmd_one_clock: got %b expected 01", {bus.cmd_err, bus.busy});
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 16'h1234);
            if (bus.rd_en || bus.ds_in || bus.io_in != 16'h0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL ignore_phy_quiet: activity=%b expected 0", seen);
        end
        step(1'b1, 16'h0000);
        checks++;
        if ({bus.busy, re_cnt - re0, we_cnt - we0} !== {1'b0, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL ignore_no_mem: busy=%b re=%0d we=%0d expected 0 0 0",
                     bus.busy, re_cnt - re0, we_cnt - we0);
        end
    endtask

    task automatic test_wrap;
        begin_xfer(2'b10);
        step(1'b0, 16'h12ED);
        step(1'b0, 16'hFFFF);
        step(1'b0, 16'hFFFF);
        step(1'b0, 16'h1111);
        checks++;
        if ({bus.ddr_2_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !==
            {2'b11, 32'hFFFF_FFFF, 16'h1111}) begin
            failures++;
            $display("FAIL wrap_word0: got %h expected %h",
                     {bus.ddr_2_en, bus.mem_we, bus.mem_addr, bus.mem_wdata},
                     {2'b11, 32'hFFFF_FFFF, 16'h1111});
        end
        step(1'b0, 16'h2222);
        checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 32'h0, 16'h2222}) begin
            failures++;
            $display("FAIL wrap_word1: got %h expected %h",
                     {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 32'h0, 16'h2222});
        end
        step(1'b1, 16'h0000);
        checks++;
        if ({bus.mem_we, bus.busy} !== 2'b00) begin
            failures++;
            $display("FAIL wrap_end: got %b expected 00", {bus.mem_we, bus.busy});
        end
    endtask

    task automatic test_sdr_partial;
        int we0;
        we0 = we_cnt;
        begin_xfer(2'b00);
        send_sdr(32'h12, 8);
        send_sdr(32'h0000_0020, 32);
        send_sdr(32'h1FF, 9);
        step(1'b1, 16'h0000);
        checks++;
        if ({bus.busy, bus.mem_we} !== 2'b00) begin
            failures++;
            $display("FAIL partial_idle: got %b expected 00", {bus.busy, bus.mem_we});
        end
        step(1'b1, 16'h0000);
        checks++;
        if (we_cnt - we0 !== 0) begin
            failures++;
            $display("FAIL partial_no_write: got %0d expected 0", we_cnt - we0);
        end
    endtask

    task automatic test_sdr_read;
        logic [15:0] exp_w [2];
        logic [15:0] word;
        logic [7:0]  re_pat;
        logic        re_ok;
        logic        bad;
        exp_w = '{16'hA5C3, 16'h0F0F};
        mem[8'h30] = 16'hA5C3; mem[8'h31] = 16'h0F0F; mem[8'h32] = 16'h0000;
        bad = 1'b0;
        begin_xfer(2'b11);
        checks++;
        if ({bus.sdr_en, bus.ddr_1_en, bus.ddr_2_en} !== 3'b100) begin
            failures++;
            $display("FAIL mode11_sdr: got %b expected 100",
                     {bus.sdr_en, bus.ddr_1_en, bus.ddr_2_en});
        end
        send_sdr(32'h0B, 8);
        send_sdr(32'h0000_0030, 32);
        for (int i = 0; i < 8; i++) begin
            re_pat[i] = bus.mem_re;
            step(1'b0, 16'h0000);
        end
        checks++;
        if (re_pat !== 8'b0100_0000) begin
            failures++;
            $display("FAIL sdr_dummy_re: got %b expected 01000000", re_pat);
        end
        for (int w = 0; w < 2; w++) begin
            word = 16'h0;
            re_ok = 1'b0;
            for (int b = 0; b < 16; b++) begin
                word = {word[14:0], bus.io_in[1]};
                if ((bus.io_in & 16'hFFFD) != 16'h0 || bus.ds_in || !bus.rd_en) bad = 1'b1;
                if (b == 13) re_ok = bus.mem_re && (bus.mem_addr == 32'h31 + 32'(w));
                step(1'b0, 16'h0000);
            end
            checks++;
            if (word !== exp_w[w]) begin
                failures++;
                $display("FAIL sdr_rd_word_%0d: got %h expected %h", w, word, exp_w[w]);
            end
            checks++;
            if (re_ok !== 1'b1) begin
                failures++;
                $display("FAIL sdr_rd_prefetch_%0d: got %b expected 1", w, re_ok);
            end
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL sdr_rd_pins: stray activity=%b expected 0", bad);
        end
        step(1'b1, 16'h0000);
    endtask

    task automatic test_reset_rdata;
        int re0;
        begin_xfer(2'b01);
        step(1'b0, 16'h0BF4);
        step(1'b0, 16'h0000);
        step(1'b0, 16'h0010);
        repeat (9) step(1'b0, 16'h0000);
        checks++;
        if ({bus.rd_en, bus.ds_in, bus.io_in} !== {2'b11, 16'hBBBB}) begin
            failures++;
            $display("FAIL rst_pre_rdata: got %h expected %h",
                     {bus.rd_en, bus.ds_in, bus.io_in}, {2'b11, 16'hBBBB});
        end
        reset = 1'b0;
        #1;
        checks++;
        if (all_out !== 73'd0) begin
            failures++;
            $display("FAIL reset_in_rdata: got %h expected 0", all_out);
        end
        @(negedge clk);
        reset = 1'b1;
        re0 = re_cnt;
        repeat (3) step(1'b0, 16'h0BF4);
        checks++;
        if ({bus.busy, re_cnt - re0} !== {1'b0, 32'd0}) begin
            failures++;
            $display("FAIL rst_no_resume: busy=%b re=%0d expected 0 0", bus.busy, re_cnt - re0);
        end
        step(1'b1, 16'h0000);
        begin_xfer(2'b01);
        checks++;
        if ({bus.busy, bus.ddr_1_en} !== 2'b11) begin
            failures++;
            $display("FAIL rst_resume: got %b expected 11", {bus.busy, bus.ddr_1_en});
        end
        step(1'b1, 16'h0000);
    endtask

    initial begin
        test_reset;
        test_ddr_read;
        test_sdr_write;
        test_bad_cmd;
        test_wrap;
        test_sdr_partial;
        test_sdr_read;
        test_reset_rdata;
        checks++;
        if (clash_cnt !== 0) begin
            failures++;
            $display("FAIL we_re_exclusive: got %0d overlaps expected 0", clash_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/slave_xspi_ctrl.md
SLAVE_XSPI_CTRL -- requirements
Module: slave_xspi_ctrl

Interface
REQ-001 SHALL have parameter RD_OP, default 8'h0B, read opcode.
REQ-002 SHALL have parameter WR_OP, default 8'h12, write opcode.
REQ-003 SHALL have parameter DUMMY_CYC, default 8, read dummy clocks; legal range 3..31.
REQ-004 SHALL have port clk  in  1  single clock for all logic.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port cs_in  in  1  chip select from PHY cs_out, active low.
REQ-007 SHALL have port mode_sel  in  2  00 SDR, 01 DDR1, 10 DDR2, 11 treated as SDR.
REQ-008 SHALL have port phy_out  in  16  captured data from PHY (SDR: bit 0 only; DDR: full word per clk).
REQ-009 SHALL have port rd_en  out  1  PHY direction: 1 = slave drives bus.
REQ-010 SHALL have ports sdr_en, ddr_1_en, ddr_2_en  out  1 each  PHY mode enables, one-hot or all zero.
REQ-011 SHALL have port io_in  out  16  read data to PHY (SDR: bit 1 only, other bits 0).
REQ-012 SHALL have port ds_in  out  1  read data strobe to PHY.
REQ-013 SHALL have ports mem_addr out 32, mem_wdata out 16, mem_we out 1, mem_re out 1, mem_rdata in 16  word memory; mem_rdata valid the clock after mem_re.
REQ-014 SHALL have ports busy out 1 (state != IDLE) and cmd_err out 1 (one-clock pulse).

Function
REQ-015 SHALL latch mode_sel into an internal mode register in IDLE on the first clock where cs_in=0; mode held until return to IDLE.
REQ-016 SHALL drive the PHY mode enables from the latched mode only while not IDLE; all zero in IDLE.
REQ-017 SHALL implement states IDLE, CMD, ADDR, DUMMY, WDATA, RDATA, IGNORE.
REQ-018 IDLE -> CMD when cs_in=0; any state -> IDLE on the clock after cs_in=1 is sampled, from every state.
REQ-019 CMD: SDR shifts 8 bits MSB-first from phy_out[0] (8 clocks); DDR takes phy_out in 1 clock as {op, ext}, requiring ext == ~op.
REQ-020 CMD exit: op==RD_OP or WR_OP (and ext valid in DDR) -> ADDR; otherwise -> IGNORE with cmd_err pulsed 1 clock.
REQ-021 ADDR: 32-bit address MSB-first; SDR 32 clocks, DDR 2 clocks (high half-word first); then RD -> DUMMY, WR -> WDATA.
REQ-022 IGNORE: all outputs to PHY and memory inactive until cs_in=1.
REQ-023 DUMMY: exactly DUMMY_CYC clocks, then RDATA; mem_re for word 0 issued in dummy clock DUMMY_CYC-2.
REQ-024 Read data SHALL be held in a 16-bit buffer loaded from mem_rdata the clock after each mem_re.
REQ-025 RDATA DDR: one word per clock on io_in; mem_re for word k issued 2 clocks before word k appears; ds_in=1 every RDATA clock.
REQ-026 RDATA SDR: each word shifted MSB-first on io_in[1], 16 clocks per word; mem_re for next word in bit clock 13; ds_in=0.
REQ-027 rd_en SHALL be 1 exactly in RDATA and 0 elsewhere.
REQ-028 WDATA DDR: each clock's phy_out written with mem_we=1 on the following clock.
REQ-029 WDATA SDR: 16 bits collected MSB-first; mem_we=1 on the clock after the 16th bit.
REQ-030 mem_addr SHALL start at the received address and increment by 1 after each mem_re/mem_we, wrapping 32'hFFFF_FFFF -> 0.
REQ-031 A partially shifted SDR write word at cs_in deassertion SHALL be discarded (no mem_we).
REQ-032 A pending mem_we for a complete word SHALL still issue on the clock after cs_in=1 is sampled.
REQ-033 mem_we and mem_re SHALL never be 1 in the same clock.

Reset
REQ-034 reset=0 SHALL immediately force IDLE, mode=SDR, and all outputs 0 (rd_en, enables, io_in, ds_in, mem_*, busy, cmd_err).
REQ-035 Reset mid-transaction SHALL abandon it with no further memory access; operation resumes on the next cs_in falling edge after reset=1.

Verification
REQ-036 DDR read: mode 01, cmd 16'h0BF4, addr 0000_0010, mem[10..12]=AAAA,BBBB,CCCC -> after 8 dummy clocks io_in=AAAA,BBBB,CCCC, rd_en=1, ds_in=1.
REQ-037 SDR write: mode 00, op 12, addr 0000_0004, 32 serial bits 1234_5678 -> mem_we at addr 4 data 1234, addr 5 data 5678.
REQ-038 Bad DDR cmd 16'h0B0B -> cmd_err 1-clock pulse, IGNORE, no mem_re/mem_we until cs_in=1.
REQ-039 DDR write at addr FFFF_FFFF, 2 words -> writes to FFFF_FFFF then 0000_0000.
REQ-040 cs_in=1 after 9 SDR write data bits -> no mem_we, IDLE next clock; reset=0 during DDR RDATA -> all outputs 0 at once.
